decode_ctrl_stage: RTL and testbench
====================================

// Module: decode_ctrl_stage
// PURPOSE
//  Registered decode/control stage between IF and EX of the pipelined RV32 core.
//  Decodes opcode into a control word, holds it in a one-entry output slot with
//  valid/ready handshake, and detects load-use hazards, inserting LOAD_BUBBLES
//  bubbles. Supports flush on taken branch/jump and counts inserted bubbles.
// PARAMETERS
//  LOAD_BUBBLES  1   bubbles inserted on load-use hazard (0..7; 0 = hazard check disabled)
//  CNT_W         16  width of saturating bubble counter
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  in_valid      in   1   instr valid from IF
//  in_ready      out  1   stage accepts instr this cycle
//  instr         in   32  instruction word
//  flush         in   1   discard held word and any stall in progress
//  out_valid     out  1   control word valid toward EX
//  out_ready     in   1   EX accepts control word
//  Branch,Jump,MemRead,MemWrite,MemtoReg,RegWrite,ALUSrc,PCSrcA out 1 each  control flags
//  ALUOp         out  2   00 add, 01 branch compare, 10 R-type, 11 I-type ALU
//  rd,rs1,rs2    out  5   register fields of held instr
//  bubble        out  1   held word is an inserted bubble (all flags 0)
//  illegal       out  1   held word had undecoded opcode (all flags 0)
//  bubble_cnt    out  CNT_W  total bubbles emitted, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, all flags/ALUOp/rd/rs1/rs2=0, bubble=0, illegal=0,
//    bubble_cnt=0, state=RUN, load-pending cleared. Reset overrides flush.
//  - in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
//  - Accept (in_valid&&in_ready): decoded word loads into slot next edge, out_valid=1.
//    Latency 1 cycle. Slot holds stable while out_valid && !out_ready.
//  - Slot drained (out_ready, no new accept/bubble) -> out_valid=0 next edge.
//  - Decode: R 0110011: RegWrite,ALUOp=10. I-ALU 0010011: RegWrite,ALUSrc,ALUOp=11.
//    LW 0000011: MemRead,MemtoReg,RegWrite,ALUSrc,ALUOp=00. SW 0100011: MemWrite,
//    ALUSrc,ALUOp=00. B 1100011: Branch,ALUOp=01. JAL 1101111: Jump,RegWrite,ALUOp=00.
//    Other: all flags 0, illegal=1 (still handshaked, out_valid=1).
//  - Source use: rs1 by R,I-ALU,LW,SW,B,JALR; rs2 by R,SW,B; none by JAL,LUI,AUIPC.
//  - Load pending: set with ld_rd=rd when a LW with rd!=0 is accepted; cleared on
//    accept of any other instr, on flush, on leaving STALL.
//  - Hazard (LOAD_BUBBLES>0): in_valid && pending && used rsX==ld_rd, evaluated only
//    when the slot can advance (!out_valid || out_ready); in_ready forced 0,
//    RUN->STALL, cnt=LOAD_BUBBLES.
//  - STALL: each cycle slot can advance, emit bubble (out_valid=1,bubble=1, flags 0),
//    cnt--, bubble_cnt++ (saturate at 2^CNT_W-1). cnt reaching 0 -> RUN, pending
//    cleared; instr then accepted normally. in_valid dropping in STALL does not abort.
//  - flush: next edge out_valid=0, state=RUN, cnt=0, pending cleared; instr presented
//    that cycle is not accepted. bubble_cnt unchanged.
//  - flush && out_ready same cycle: flush wins, no word emitted.
// CONFIGURATION
//  CTRL_UIMM_EN defined: decode LUI 0110111 (RegWrite,ALUSrc,ALUOp=00),
//    AUIPC 0010111 (RegWrite,ALUSrc,PCSrcA,ALUOp=00), JALR 1100111 (Jump,RegWrite,
//    ALUSrc,ALUOp=00, uses rs1, participates in hazard check).
//  CTRL_UIMM_EN undefined: those opcodes decode illegal; PCSrcA tied 0.
// TESTING
//  - rst=1 2 cycles -> all outputs 0, in_ready=1 after release with out_ready=1.
//  - add x3,x1,x2 then sw; out_ready=1 -> RegWrite=1,ALUOp=10 then MemWrite=1,
//    ALUSrc=1, one per cycle, no bubbles.
//  - lw x5,0(x1); add x6,x5,x2; LOAD_BUBBLES=2 -> lw, 2 bubbles, add; bubble_cnt=2.
//  - lw x0,..; add x6,x0,x2 -> no bubble; lw x5; jal x1 -> no bubble.
//  - out_ready=0 for 3 cycles holding lw -> word stable, in_ready=0; flush mid-STALL
//    -> out_valid=0 next cycle, state RUN, bubble_cnt unchanged.
//  - opcode 0110111: without CTRL_UIMM_EN illegal=1; with it RegWrite=1,ALUSrc=1.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   Registered decode/control stage between IF and EX of the RV32 pipeline.
//   Decodes the opcode into a control word and holds it in a one-entry output
//   slot with a valid/ready handshake. Detects load-use hazards and inserts
//   LOAD_BUBBLES bubbles. Flush discards the held word and any stall, and the
//   stage keeps a saturating count of emitted bubbles.
//
//   Optional feature macro: CTRL_UIMM_EN (decode LUI, AUIPC, JALR; otherwise
//   those opcodes decode as illegal and PCSrcA stays 0).
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  instruction handshake from IF
//   instr                32-bit instruction word
//   flush                drop held word and any stall in progress
//   out_valid/out_ready  control word handshake toward EX
//   Branch..PCSrcA       control flags of the held word
//   ALUOp                00 add, 01 branch compare, 10 R-type, 11 I-type ALU
//   rd, rs1, rs2         register fields of the held word
//   bubble, illegal      held word is a bubble / had an undecoded opcode
//   bubble_cnt           saturating count of emitted bubbles
//
// state    | meaning
// ST_RUN   | normal decode, accepts instructions when the slot can advance
// ST_STALL | load-use stall, emits one bubble per slot advance until cnt hits 0

module decode_ctrl_stage #(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Branch,
  output logic             Jump,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             PCSrcA,
  output logic [1:0]       ALUOp,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             bubble,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // flag vector order: {Branch, Jump, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, PCSrcA}
  logic [7:0]       flags_q, flags_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic             out_valid_q, out_valid_d;
  logic             bubble_q, bubble_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [0:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [4:0]       ld_rd_q, ld_rd_d;

  logic [6:0] opcode;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [7:0] dec_flags;
  logic [1:0] dec_alu_op;
  logic       dec_illegal, dec_use1, dec_use2, dec_is_lw;
  logic       advance, hazard, accept;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign in_rd  = instr[11:7];
  assign in_rs1 = instr[19:15];
  assign in_rs2 = instr[24:20];
  assign unused_instr_bits = ^{instr[31:25], instr[14:12]};

  always_comb begin
    dec_flags   = 8'b0;
    dec_alu_op  = 2'b00;
    dec_illegal = 1'b0;
    dec_use1    = 1'b0;
    dec_use2    = 1'b0;
    dec_is_lw   = 1'b0;
    case (opcode)
      7'b0110011: begin dec_flags = 8'b0000_0100; dec_alu_op = 2'b10; dec_use1 = 1'b1; dec_use2 = 1'b1; end
      7'b0010011: begin dec_flags = 8'b0000_0110; dec_alu_op = 2'b11; dec_use1 = 1'b1; end
      7'b0000011: begin dec_flags = 8'b0010_1110; dec_use1 = 1'b1; dec_is_lw = 1'b1; end
      7'b0100011: begin dec_flags = 8'b0001_0010; dec_use1 = 1'b1; dec_use2 = 1'b1; end
      7'b1100011: begin dec_flags = 8'b1000_0000; dec_alu_op = 2'b01; dec_use1 = 1'b1; dec_use2 = 1'b1; end
      7'b1101111: begin dec_flags = 8'b0100_0100; end
`ifdef CTRL_UIMM_EN
      7'b0110111: begin dec_flags = 8'b0000_0110; end
      7'b0010111: begin dec_flags = 8'b0000_0111; end
      7'b1100111: begin dec_flags = 8'b0100_0110; dec_use1 = 1'b1; end
`endif
      default:    begin dec_illegal = 1'b1; end
    endcase
  end

  // Hazard is only meaningful when the slot could move this cycle; otherwise
  // the stage is blocked by EX anyway and the check is deferred.
  assign advance = !out_valid_q || out_ready;
  assign hazard  = (LOAD_BUBBLES > 0) && (state_q == ST_RUN) && in_valid && pend_q && advance &&
                   ((dec_use1 && (in_rs1 == ld_rd_q)) || (dec_use2 && (in_rs2 == ld_rd_q)));
  assign in_ready = (state_q == ST_RUN) && !flush && advance && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    flags_d      = flags_q;
    alu_op_d     = alu_op_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    out_valid_d  = out_valid_q;
    bubble_d     = bubble_q;
    illegal_d    = illegal_q;
    bubble_cnt_d = bubble_cnt_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    ld_rd_d      = ld_rd_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_RUN;
      cnt_d       = 3'd0;
      pend_d      = 1'b0;
    end else if (state_q == ST_STALL) begin
      if (advance) begin
        out_valid_d = 1'b1;
        bubble_d    = 1'b1;
        illegal_d   = 1'b0;
        flags_d     = 8'b0;
        alu_op_d    = 2'b00;
        rd_d        = 5'd0;
        rs1_d       = 5'd0;
        rs2_d       = 5'd0;
        cnt_d       = cnt_q - 3'd1;
        if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_d = bubble_cnt_q + 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
          pend_d  = 1'b0;
        end
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      bubble_d    = 1'b0;
      illegal_d   = dec_illegal;
      flags_d     = dec_flags;
      alu_op_d    = dec_alu_op;
      rd_d        = in_rd;
      rs1_d       = in_rs1;
      rs2_d       = in_rs2;
      pend_d      = dec_is_lw && (in_rd != 5'd0);
      ld_rd_d     = in_rd;
    end else if (hazard) begin
      out_valid_d = 1'b0;
      state_d     = ST_STALL;
      cnt_d       = 3'(LOAD_BUBBLES);
    end else if (advance) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= 8'b0;
      alu_op_q     <= 2'b00;
      rd_q         <= 5'd0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      out_valid_q  <= 1'b0;
      bubble_q     <= 1'b0;
      illegal_q    <= 1'b0;
      bubble_cnt_q <= '0;
      state_q      <= ST_RUN;
      cnt_q        <= 3'd0;
      pend_q       <= 1'b0;
      ld_rd_q      <= 5'd0;
    end else begin
      flags_q      <= flags_d;
      alu_op_q     <= alu_op_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      out_valid_q  <= out_valid_d;
      bubble_q     <= bubble_d;
      illegal_q    <= illegal_d;
      bubble_cnt_q <= bubble_cnt_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      ld_rd_q      <= ld_rd_d;
    end
  end

  assign {Branch, Jump, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, PCSrcA} = flags_q;
  assign ALUOp      = alu_op_q;
  assign rd         = rd_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign out_valid  = out_valid_q;
  assign bubble     = bubble_q;
  assign illegal    = illegal_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr;
  logic        Branch, Jump, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, PCSrcA;
  logic [1:0]  ALUOp;
  logic [4:0]  rd, rs1, rs2;
  logic        bubble, illegal;
  logic [15:0] bubble_cnt;

  int nchecks = 0;
  int npass   = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.LOAD_BUBBLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .Branch(Branch), .Jump(Jump), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .PCSrcA(PCSrcA),
    .ALUOp(ALUOp), .rd(rd), .rs1(rs1), .rs2(rs2), .bubble(bubble), .illegal(illegal),
    .bubble_cnt(bubble_cnt)
  );

  logic [7:0] flags_act;
  assign flags_act = {Branch, Jump, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, PCSrcA};

  // emitted words: {bubble, illegal, MemRead, RegWrite, rd}
  logic [8:0] mon_q[$];
  logic       mon_en = 1'b0;
  always @(negedge clk)
    if (mon_en && !rst && out_valid && out_ready)
      mon_q.push_back({bubble, illegal, MemRead, RegWrite, rd});

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  flags;
    logic [1:0]  aluop;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    instr = w;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", {31'b0, got}, 32'd1);
  endtask

  function automatic logic [8:0] mon_at(input int k);
    return (mon_q.size() > k) ? mon_q[k] : 9'h1FF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h002081B3, 8'b0000_0100, 2'b10, 1'b0, 5'd3,  5'd1};
    vecs[1] = '{32'h0020A023, 8'b0001_0010, 2'b00, 1'b0, 5'd0,  5'd1};
    vecs[2] = '{32'h00508213, 8'b0000_0110, 2'b11, 1'b0, 5'd4,  5'd1};
    vecs[3] = '{32'h0000A383, 8'b0010_1110, 2'b00, 1'b0, 5'd7,  5'd1};
    vecs[4] = '{32'h00208063, 8'b1000_0000, 2'b01, 1'b0, 5'd0,  5'd1};
    vecs[5] = '{32'h000000EF, 8'b0100_0100, 2'b00, 1'b0, 5'd1,  5'd0};
`ifdef CTRL_UIMM_EN
    vecs[6] = '{32'h000004B7, 8'b0000_0110, 2'b00, 1'b0, 5'd9,  5'd0};
    vecs[7] = '{32'h00000517, 8'b0000_0111, 2'b00, 1'b0, 5'd10, 5'd0};
    vecs[8] = '{32'h000100E7, 8'b0100_0110, 2'b00, 1'b0, 5'd1,  5'd2};
`else
    vecs[6] = '{32'h000004B7, 8'b0000_0000, 2'b00, 1'b1, 5'd9,  5'd0};
    vecs[7] = '{32'h00000517, 8'b0000_0000, 2'b00, 1'b1, 5'd10, 5'd0};
    vecs[8] = '{32'h000100E7, 8'b0000_0000, 2'b00, 1'b1, 5'd1,  5'd2};
`endif
    vecs[9] = '{32'hFFFFFFFF, 8'b0000_0000, 2'b00, 1'b1, 5'd31, 5'd31};

    // reset
    rst = 1'b1; in_valid = 1'b0; instr = 32'h0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_flags", {24'b0, flags_act}, 32'd0);
    check("rst_fields", {15'b0, ALUOp, rd, rs1, rs2}, 32'd0);
    check("rst_bub_ill", {30'b0, bubble, illegal}, 32'd0);
    check("rst_bubble_cnt", {16'b0, bubble_cnt}, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // table-driven decode, streaming one per cycle
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      instr = vecs[i].instr;
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      step();
      check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d_flags", i), {24'b0, flags_act}, {24'b0, vecs[i].flags});
      check($sformatf("vec%0d_aluop", i), {30'b0, ALUOp}, {30'b0, vecs[i].aluop});
      check($sformatf("vec%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
      check($sformatf("vec%0d_rd", i), {27'b0, rd}, {27'b0, vecs[i].rd});
      check($sformatf("vec%0d_rs1", i), {27'b0, rs1}, {27'b0, vecs[i].rs1});
      check($sformatf("vec%0d_bubble", i), {31'b0, bubble}, 32'd0);
    end
    in_valid = 1'b0;
    step();
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // lw x5,0(x1); add x6,x5,x2 -> lw, 2 bubbles, add
    mon_q.delete();
    mon_en = 1'b1;
    send(32'h0000A283);
    send(32'h00228333);
    repeat (4) step();
    check("lu_count", mon_q.size(), 32'd4);
    check("lu_w0_lw", {23'b0, mon_at(0)}, {23'b0, 9'b0_0_1_1_00101});
    check("lu_w1_bub", {23'b0, mon_at(1)}, {23'b0, 9'b1_0_0_0_00000});
    check("lu_w2_bub", {23'b0, mon_at(2)}, {23'b0, 9'b1_0_0_0_00000});
    check("lu_w3_add", {23'b0, mon_at(3)}, {23'b0, 9'b0_0_0_1_00110});
    check("lu_bubble_cnt", {16'b0, bubble_cnt}, 32'd2);

    // lw x0 then add using x0 -> no bubble
    mon_q.delete();
    send(32'h0000A003);
    send(32'h00200333);
    repeat (3) step();
    check("x0_count", mon_q.size(), 32'd2);
    check("x0_w1_add", {23'b0, mon_at(1)}, {23'b0, 9'b0_0_0_1_00110});
    // lw x5 then jal x1 -> no bubble
    mon_q.delete();
    send(32'h0000A283);
    send(32'h000000EF);
    repeat (3) step();
    check("jal_count", mon_q.size(), 32'd2);
    check("jal_w1", {23'b0, mon_at(1)}, {23'b0, 9'b0_0_0_1_00001});
    check("nobub_bubble_cnt", {16'b0, bubble_cnt}, 32'd2);
    mon_en = 1'b0;

    // hold lw under backpressure, then stall and flush mid-stall
    out_ready = 1'b0;
    send(32'h0000A283);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("hold%0d_word", k), {26'b0, MemRead, rd}, {26'b0, 1'b1, 5'd5});
      check($sformatf("hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b1;
    instr = 32'h00228333;
    #1;
    check("hold_add_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("hold_still_lw", {26'b0, MemRead, rd}, {26'b0, 1'b1, 5'd5});
    out_ready = 1'b1;
    #1;
    check("haz_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("stall_out_valid", {31'b0, out_valid}, 32'd0);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("stall_bubble", {30'b0, out_valid, bubble}, 32'd3);
    check("stall_bubble_cnt", {16'b0, bubble_cnt}, 32'd3);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_bubble_cnt", {16'b0, bubble_cnt}, 32'd3);
    #1;
    check("post_flush_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("post_flush_add", {25'b0, out_valid, bubble, RegWrite, rd},
          {25'b0, 1'b1, 1'b0, 1'b1, 5'd6});
    check("final_bubble_cnt", {16'b0, bubble_cnt}, 32'd3);

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
